// File: rtl/secuenciador_motores_pkg.sv
// -----------------------------------------------------------------------------
// secuenciador_pkg
// Shared definitions for the sequential motor timer: FSM state encoding,
// default build parameters and the channel-index width helper.
// -----------------------------------------------------------------------------
package secuenciador_pkg;

   localparam int DEF_N_CH    = 3;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_PRESC_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width of a channel index; never narrower than one bit so N_CH=1 still works.
   function automatic int ch_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/secuenciador_motores_if.sv
// -----------------------------------------------------------------------------
// secuenciador_motores_if
// Control/status bundle of the motor sequencer.
//   master : drives start, abort, presc, dur; observes status
//   slave  : the sequencer; drives busy, motor_on, ch_idx, ch_done, done
// -----------------------------------------------------------------------------
interface secuenciador_motores_if
   import secuenciador_pkg::*;
#(
   parameter int N_CH    = DEF_N_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PRESC_W = DEF_PRESC_W
);
   localparam int CH_W = ch_w(N_CH);

   logic                     start;
   logic                     abort;
   logic [PRESC_W-1:0]       presc;
   logic [N_CH*CNT_W-1:0]    dur;
   logic                     busy;
   logic [N_CH-1:0]          motor_on;
   logic [CH_W-1:0]          ch_idx;
   logic [N_CH-1:0]          ch_done;
   logic                     done;

   modport master (
      output start, abort, presc, dur,
      input  busy, motor_on, ch_idx, ch_done, done
   );

   modport slave (
      input  start, abort, presc, dur,
      output busy, motor_on, ch_idx, ch_done, done
   );
endinterface

// File: rtl/secuenciador_motores_prescaler_tick.sv
// -----------------------------------------------------------------------------
// prescaler_tick
// Divides the clock into time units of p_eff cycles.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous counter clear (wins over en)
//   en         : count enable
//   p_eff      : cycles per unit (caller guarantees >= 1 while enabled)
//   tick       : high on the last cycle of each unit
// -----------------------------------------------------------------------------
module prescaler_tick
   import secuenciador_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] p_eff,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt_r;
   logic               tick_s;

   assign tick_s = en && (cnt_r == (p_eff - PRESC_W'(1)));
   assign tick   = tick_s;

   // Cycle counter within the current unit, wrapping on tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr || tick_s) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= cnt_r + PRESC_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end
endmodule

// File: rtl/secuenciador_motores.sv
// -----------------------------------------------------------------------------
// secuenciador_motores
// Sequential motor timer: on start, latches per-channel durations and the
// prescaler, then enables each nonzero channel's motor in index order for
// dur*p_eff cycles, with no gap and no overlap.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of secuenciador_motores_if
//                (start/abort/presc/dur in; busy/motor_on/ch_idx/ch_done/done out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module secuenciador_motores
   import secuenciador_pkg::*;
#(
   parameter int N_CH    = DEF_N_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   secuenciador_motores_if.slave  bus
);
   localparam int CH_W = ch_w(N_CH);

   state_t                state_r;
   logic [N_CH*CNT_W-1:0] dur_sh_r;
   logic [PRESC_W-1:0]    p_eff_r;
   logic [CH_W-1:0]       ch_r;
   logic [CNT_W-1:0]      unit_r;
   logic                  busy_r;
   logic [N_CH-1:0]       motor_on_r;
   logic [N_CH-1:0]       ch_done_r;
   logic                  done_r;

   logic                  run_s;
   logic                  tick_s;
   logic                  clr_s;
   logic                  chan_end_s;
   logic [CNT_W-1:0]      cur_dur_s;
   logic                  first_valid_s;
   logic [CH_W-1:0]       first_ch_s;
   logic                  next_valid_s;
   logic [CH_W-1:0]       next_ch_s;

   function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
      return N_CH'(1) << idx;
   endfunction

   assign run_s      = (state_r == ST_RUN);
   assign chan_end_s = run_s && tick_s && (unit_r == (cur_dur_s - CNT_W'(1)));
   assign clr_s      = !run_s || bus.abort || chan_end_s;

   prescaler_tick #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .en    (run_s),
      .p_eff (p_eff_r),
      .tick  (tick_s)
   );

   // Duration of the active channel, taken from the shadow copy.
   always_comb begin
      cur_dur_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (CH_W'(i) == ch_r) begin
            cur_dur_s = dur_sh_r[i*CNT_W +: CNT_W];
         end else begin
            cur_dur_s = cur_dur_s;
         end
      end
   end

   // Priority searches: lowest nonzero channel of the live inputs (for start)
   // and lowest nonzero shadow channel above the current one (for handover).
   // Descending loops let the lowest matching index win.
   always_comb begin
      first_valid_s = 1'b0;
      first_ch_s    = '0;
      next_valid_s  = 1'b0;
      next_ch_s     = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.dur[i*CNT_W +: CNT_W] != '0) begin
            first_valid_s = 1'b1;
            first_ch_s    = CH_W'(i);
         end else begin
            first_valid_s = first_valid_s;
         end
         if ((i > int'(ch_r)) && (dur_sh_r[i*CNT_W +: CNT_W] != '0)) begin
            next_valid_s = 1'b1;
            next_ch_s    = CH_W'(i);
         end else begin
            next_valid_s = next_valid_s;
         end
      end
   end

   // Sequencer FSM with unit counter, shadow registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         dur_sh_r   <= '0;
         p_eff_r    <= '0;
         ch_r       <= '0;
         unit_r     <= '0;
         busy_r     <= 1'b0;
         motor_on_r <= '0;
         ch_done_r  <= '0;
         done_r     <= 1'b0;
      end else begin
         ch_done_r <= '0;
         done_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               unit_r <= '0;
               if (bus.start && !bus.abort) begin
                  dur_sh_r <= bus.dur;
                  p_eff_r  <= (bus.presc == '0) ? PRESC_W'(1) : bus.presc;
                  if (first_valid_s) begin
                     state_r    <= ST_RUN;
                     ch_r       <= first_ch_s;
                     motor_on_r <= onehot(first_ch_s);
                     busy_r     <= 1'b1;
                  end else begin
                     // Nothing to run: report completion without going busy.
                     done_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  state_r    <= ST_IDLE;
                  ch_r       <= '0;
                  unit_r     <= '0;
                  busy_r     <= 1'b0;
                  motor_on_r <= '0;
               end else if (chan_end_s) begin
                  ch_done_r <= onehot(ch_r);
                  unit_r    <= '0;
                  if (next_valid_s) begin
                     ch_r       <= next_ch_s;
                     motor_on_r <= onehot(next_ch_s);
                  end else begin
                     state_r    <= ST_IDLE;
                     ch_r       <= '0;
                     busy_r     <= 1'b0;
                     motor_on_r <= '0;
                     done_r     <= 1'b1;
                  end
               end else if (tick_s) begin
                  unit_r <= unit_r + CNT_W'(1);
               end else begin
                  unit_r <= unit_r;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               ch_r       <= '0;
               unit_r     <= '0;
               busy_r     <= 1'b0;
               motor_on_r <= '0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.motor_on = motor_on_r;
   assign bus.ch_idx   = ch_r;
   assign bus.ch_done  = ch_done_r;
   assign bus.done     = done_r;
endmodule
